// File: rtl/reg_file_wb.sv
// Architectural register file with a write-pending scoreboard and operand stall logic.
// Optional same-cycle writeback forwarding is compiled in with REGFILE_BYPASS_EN.
module reg_file_wb #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regWriteW,
    input  logic [4:0]      writeRegW,
    input  logic [DW-1:0]   resultW,
    input  logic [4:0]      rsD,
    input  logic [4:0]      rtD,
    input  logic            useRsD,
    input  logic            useRtD,
    input  logic            markEnD,
    input  logic [4:0]      markRegD,
    output logic [DW-1:0]   rd1D,
    output logic [DW-1:0]   rd2D,
    output logic            stallD,
    output logic [NREG-1:0] busyVec
);

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] busyNext;
    logic            writeCommit;
    logic            bypassRs;
    logic            bypassRt;
    logic            hazRs;
    logic            hazRt;

    assign writeCommit = regWriteW && (writeRegW != '0);

`ifdef REGFILE_BYPASS_EN
    assign bypassRs = regWriteW && (writeRegW == rsD);
    assign bypassRt = regWriteW && (writeRegW == rtD);
`else
    assign bypassRs = 1'b0;
    assign bypassRt = 1'b0;
`endif

    always_comb begin
        rd1D = '0;
        rd2D = '0;
        if (rsD != '0) begin
            rd1D = bypassRs ? resultW : regs[rsD];
        end
        if (rtD != '0) begin
            rd2D = bypassRt ? resultW : regs[rtD];
        end
    end

    always_comb begin
        hazRs  = useRsD && (rsD != '0) && busyVec[rsD] && !bypassRs;
        hazRt  = useRtD && (rtD != '0) && busyVec[rtD] && !bypassRt;
        stallD = hazRs || hazRt;
    end

    // Mark is applied after the clear so a same-index set/clear leaves the bit set.
    always_comb begin
        busyNext = busyVec;
        if (writeCommit) begin
            busyNext[writeRegW] = 1'b0;
        end
        if (markEnD && !stallD && (markRegD != '0)) begin
            busyNext[markRegD] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs    <= '{default: '0};
            busyVec <= '0;
        end else begin
            if (writeCommit) begin
                regs[writeRegW] <= resultW;
            end
            busyVec <= busyNext;
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed test-plan steps followed by random traffic,
// all checked against an array-based reference model of the register file and scoreboard.
module tb_reg_file_wb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        regWriteW;
    logic [4:0]  writeRegW;
    logic [31:0] resultW;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic        useRsD;
    logic        useRtD;
    logic        markEnD;
    logic [4:0]  markRegD;
    logic [31:0] rd1D;
    logic [31:0] rd2D;
    logic        stallD;
    logic [31:0] busyVec;

    int cmpCount = 0;
    int errCount = 0;

    logic [31:0] mregs [32];
    bit          mbusy [32];

    always #5 clk = ~clk;

    reg_file_wb #(.NREG(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .regWriteW(regWriteW), .writeRegW(writeRegW), .resultW(resultW),
        .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
        .markEnD(markEnD), .markRegD(markRegD),
        .rd1D(rd1D), .rd2D(rd2D), .stallD(stallD), .busyVec(busyVec)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: a register's value is what was last written, forwarded when bypass is on.
    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (BYP && regWriteW && writeRegW == idx) return resultW;
        return mregs[idx];
    endfunction

    function automatic bit mhaz(input logic use_, input logic [4:0] idx);
        if (!use_ || idx == 0 || !mbusy[idx]) return 1'b0;
        if (BYP && regWriteW && writeRegW == idx) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] mbusyVec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mbusy[i];
        return v;
    endfunction

    task automatic idle();
        rst = 1'b0; regWriteW = 1'b0; writeRegW = '0; resultW = '0;
        rsD = '0; rtD = '0; useRsD = 1'b0; useRtD = 1'b0;
        markEnD = 1'b0; markRegD = '0;
    endtask

    task automatic sample();
        @(negedge clk);
        chk("rd1D", rd1D, mread(rsD));
        chk("rd2D", rd2D, mread(rtD));
        chk("stallD", {31'h0, stallD}, {31'h0, mhaz(useRsD, rsD) || mhaz(useRtD, rtD)});
        chk("busyVec", busyVec, mbusyVec());
    endtask

    task automatic commit();
        bit stall;
        @(posedge clk);
        stall = mhaz(useRsD, rsD) || mhaz(useRtD, rtD);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mregs[i] = 32'h0;
                mbusy[i] = 1'b0;
            end
        end else begin
            if (regWriteW && writeRegW != 0) begin
                mregs[writeRegW] = resultW;
                mbusy[writeRegW] = 1'b0;
            end
            if (markEnD && !stall && markRegD != 0) mbusy[markRegD] = 1'b1;
        end
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        commit();
        commit();
        idle();

        // After reset every register reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            rsD = 5'(i); rtD = 5'(31 - i); useRsD = 1'b1; useRtD = 1'b1;
            sample();
            chk("rst_rd1", rd1D, 32'h0);
            chk("rst_busy", busyVec, 32'h0);
            commit();
        end

        // Write r5=3 and read it in the same cycle.
        idle();
        regWriteW = 1'b1; writeRegW = 5'd5; resultW = 32'd3; rsD = 5'd5;
        sample();
        chk("raw_same", rd1D, BYP ? 32'd3 : 32'd0);
        commit();
        idle(); rsD = 5'd5;
        sample();
        chk("raw_next", rd1D, 32'd3);
        commit();

        // r0 is never written nor marked.
        idle();
        regWriteW = 1'b1; writeRegW = 5'd0; resultW = 32'hFFFF_FFFF;
        markEnD = 1'b1; markRegD = 5'd0;
        sample();
        commit();
        idle();
        sample();
        chk("r0_read", rd1D, 32'h0);
        chk("r0_busy", {31'h0, busyVec[0]}, 32'h0);
        commit();

        // Mark r7, then stall on it; a mark issued while stalled is dropped.
        idle(); markEnD = 1'b1; markRegD = 5'd7;
        sample(); commit();
        idle(); rtD = 5'd7; useRtD = 1'b1; markEnD = 1'b1; markRegD = 5'd8;
        sample();
        chk("stall_r7", {31'h0, stallD}, 32'd1);
        commit();
        idle(); rtD = 5'd7; useRtD = 1'b1;
        regWriteW = 1'b1; writeRegW = 5'd7; resultW = 32'h1234;
        sample();
        chk("stall_wb", {31'h0, stallD}, BYP ? 32'd0 : 32'd1);
        chk("busy_r8", {31'h0, busyVec[8]}, 32'd0);
        if (BYP) chk("byp_rd2", rd2D, 32'h1234);
        commit();
        idle(); rtD = 5'd7; useRtD = 1'b1;
        sample();
        chk("stall_clr", {31'h0, stallD}, 32'd0);
        chk("rd2_r7", rd2D, 32'h1234);
        commit();

        // Same-cycle mark and writeback of r9: data lands, bit stays set.
        idle(); markEnD = 1'b1; markRegD = 5'd9;
        regWriteW = 1'b1; writeRegW = 5'd9; resultW = 32'd1;
        sample(); commit();
        idle(); rsD = 5'd9;
        sample();
        chk("r9_data", rd1D, 32'd1);
        chk("r9_busy", {31'h0, busyVec[9]}, 32'd1);
        commit();

        // Reset overrides a concurrent write and clears pending marks.
        idle(); markEnD = 1'b1; markRegD = 5'd3;
        sample(); commit();
        idle(); rst = 1'b1; regWriteW = 1'b1; writeRegW = 5'd3; resultW = 32'd9;
        sample(); commit();
        idle(); rsD = 5'd3;
        sample();
        chk("rst_r3", rd1D, 32'h0);
        chk("rst_busy2", busyVec, 32'h0);
        commit();

        // Random traffic on a narrow index range to provoke hazards and collisions.
        for (int n = 0; n < 2000; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            regWriteW = $urandom_range(0, 1);
            writeRegW = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            resultW   = $urandom;
            rsD       = 5'($urandom_range(0, 7));
            rtD       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            useRsD    = $urandom_range(0, 1);
            useRtD    = $urandom_range(0, 1);
            markEnD   = $urandom_range(0, 1);
            markRegD  = 5'($urandom_range(0, 7));
            sample();
            commit();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
